// File: rtl/rv32im_lsu_ostd.sv
// rv32im_lsu_ostd: RV32IM load/store unit with an in-order queue of outstanding DMEM requests.
// Misaligned requests and DMEM responses are answered combinationally; a DMEM error blocks new requests until the queue drains.
module rv32im_lsu_ostd #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int OST_DEPTH = 2,
    localparam int LSU_OPCODE_SIZE = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       exu2lsu_req_i,
    input  logic [LSU_OPCODE_SIZE-1:0] exu2lsu_cmd_i,
    input  logic [ADDR_W-1:0]          exu2lsu_addr_i,
    input  logic [DATA_W-1:0]          exu2lsu_sdata_i,
    output logic                       lsu2exu_req_ack_o,
    output logic                       lsu2exu_ready_o,
    output logic [DATA_W-1:0]          lsu2exu_ldata_o,
    output logic                       lsu2exu_exception_o,
    output logic [3:0]                 lsu2exu_exception_code_o,
    output logic                       lsu2dmem_req_o,
    output logic                       lsu2dmem_cmd_o,
    output logic [2:0]                 lsu2dmem_width_o,
    output logic [ADDR_W-1:0]          lsu2dmem_addr_o,
    output logic [DATA_W-1:0]          lsu2dmem_wdata_o,
    output logic [DATA_W/8-1:0]        lsu2dmem_be_o,
    input  logic                       dmem2lsu_req_ack_i,
    input  logic [DATA_W-1:0]          dmem2lsu_rdata_i,
    input  logic [1:0]                 dmem2lsu_resp_i
);
    localparam logic [3:0] LSU_CMD_LB = 4'd1, LSU_CMD_LH = 4'd2, LSU_CMD_LW = 4'd3, LSU_CMD_LBU = 4'd4,
                           LSU_CMD_LHU = 4'd5, LSU_CMD_SB = 4'd6, LSU_CMD_SH = 4'd7, LSU_CMD_SW = 4'd8;
    localparam logic MEM_CMD_RD = 1'b0, MEM_CMD_WR = 1'b1;
    localparam logic [2:0] MEM_WIDTH_BYTE = 3'd0, MEM_WIDTH_HWORD = 3'd1, MEM_WIDTH_WORD = 3'd2;
    localparam logic [1:0] MEM_RESP_RDY_OK = 2'd1, MEM_RESP_RDY_ER = 2'd2;
    localparam int PW = OST_DEPTH > 1 ? $clog2(OST_DEPTH) : 1;
    localparam int CW = $clog2(OST_DEPTH) + 1;

    if (DATA_W != 32) begin : g_bad_width
        $error("rv32im_lsu_ostd supports DATA_W = 32 only");
    end

    logic [3:0]      q_cmd [OST_DEPTH];
    logic [1:0]      q_off [OST_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt;
    logic            flush_pending, stray_resp_err;
    logic            req_v, is_load, is_store, is_byte, is_half, is_word, misaligned;
    logic            q_full, q_empty, resp_any, resp_er, resp_pop, push, mis_rpt, head_load;
    logic [3:0]      head_cmd;
    logic [1:0]      head_off;
    logic [DATA_W-1:0] rsh, ld_ext;

    assign req_v      = rst & exu2lsu_req_i;
    assign is_load    = exu2lsu_cmd_i inside {LSU_CMD_LB, LSU_CMD_LH, LSU_CMD_LW, LSU_CMD_LBU, LSU_CMD_LHU};
    assign is_store   = exu2lsu_cmd_i inside {LSU_CMD_SB, LSU_CMD_SH, LSU_CMD_SW};
    assign is_byte    = exu2lsu_cmd_i inside {LSU_CMD_LB, LSU_CMD_LBU, LSU_CMD_SB};
    assign is_half    = exu2lsu_cmd_i inside {LSU_CMD_LH, LSU_CMD_LHU, LSU_CMD_SH};
    assign is_word    = exu2lsu_cmd_i inside {LSU_CMD_LW, LSU_CMD_SW};
    assign misaligned = req_v & ((is_word & |exu2lsu_addr_i[1:0]) | (is_half & exu2lsu_addr_i[0]));
    assign q_full     = cnt == CW'(OST_DEPTH);
    assign q_empty    = cnt == '0;
    assign resp_er    = dmem2lsu_resp_i == MEM_RESP_RDY_ER;
    assign resp_any   = rst & (resp_er | dmem2lsu_resp_i == MEM_RESP_RDY_OK);
    assign resp_pop   = resp_any & ~q_empty;
    // a response owns the EXU return path; a misaligned request waits for a quiet cycle
    assign mis_rpt    = misaligned & ~resp_any;

    assign lsu2dmem_req_o    = req_v & (is_load | is_store) & ~misaligned & ~q_full & ~flush_pending;
    assign push              = lsu2dmem_req_o & dmem2lsu_req_ack_i;
    assign lsu2exu_req_ack_o = push;
    assign lsu2dmem_cmd_o    = lsu2dmem_req_o & is_store ? MEM_CMD_WR : MEM_CMD_RD;
    assign lsu2dmem_width_o  = ~lsu2dmem_req_o ? MEM_WIDTH_BYTE : is_byte ? MEM_WIDTH_BYTE :
                               is_half ? MEM_WIDTH_HWORD : MEM_WIDTH_WORD;
    assign lsu2dmem_addr_o   = rst ? exu2lsu_addr_i : '0;
    assign lsu2dmem_wdata_o  = ~(lsu2dmem_req_o & is_store) ? '0 : is_byte ? {4{exu2lsu_sdata_i[7:0]}} :
                               is_half ? {2{exu2lsu_sdata_i[15:0]}} : exu2lsu_sdata_i;
    assign lsu2dmem_be_o     = ~(lsu2dmem_req_o & is_store) ? 4'b0000 : is_byte ? 4'b0001 << exu2lsu_addr_i[1:0] :
                               is_half ? 4'b0011 << exu2lsu_addr_i[1:0] : 4'b1111;

    assign head_cmd  = q_cmd[rd_ptr];
    assign head_off  = q_off[rd_ptr];
    assign head_load = head_cmd inside {LSU_CMD_LB, LSU_CMD_LH, LSU_CMD_LW, LSU_CMD_LBU, LSU_CMD_LHU};
    assign rsh       = dmem2lsu_rdata_i >> {head_off, 3'b000};
    assign ld_ext    = head_cmd == LSU_CMD_LB  ? {{24{rsh[7]}}, rsh[7:0]} :
                       head_cmd == LSU_CMD_LH  ? {{16{rsh[15]}}, rsh[15:0]} :
                       head_cmd == LSU_CMD_LBU ? {24'h0, rsh[7:0]} :
                       head_cmd == LSU_CMD_LHU ? {16'h0, rsh[15:0]} :
                       head_cmd == LSU_CMD_LW  ? rsh : '0;

    assign lsu2exu_ready_o          = resp_pop | mis_rpt;
    assign lsu2exu_ldata_o          = resp_pop ? ld_ext : '0;
    assign lsu2exu_exception_o      = resp_pop ? resp_er : mis_rpt;
    assign lsu2exu_exception_code_o = resp_pop ? (resp_er ? (head_load ? 4'd5 : 4'd7) : 4'd0) :
                                      mis_rpt ? (is_load ? 4'd4 : 4'd6) : 4'd0;

    always_ff @(posedge clk) begin
        if (push) begin
            q_cmd[wr_ptr] <= exu2lsu_cmd_i;
            q_off[wr_ptr] <= exu2lsu_addr_i[1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cnt            <= '0;
            flush_pending  <= 1'b0;
            stray_resp_err <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr == PW'(OST_DEPTH - 1) ? '0 : wr_ptr + PW'(1);
            if (resp_pop)
                rd_ptr <= rd_ptr == PW'(OST_DEPTH - 1) ? '0 : rd_ptr + PW'(1);
            cnt <= cnt + CW'(push) - CW'(resp_pop);
            if (resp_pop & resp_er)
                flush_pending <= 1'b1;
            else if (q_empty)
                flush_pending <= 1'b0;
            if (resp_any & q_empty)
                stray_resp_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_rv32im_lsu_ostd.sv
// tb_rv32im_lsu_ostd: scoreboard bench for the outstanding-request LSU.
// Expected responses are queued at request acceptance and checked when the DUT reports them.
module tb_rv32im_lsu_ostd;
    localparam logic [3:0] NONE = 4'd0, LB = 4'd1, LH = 4'd2, LW = 4'd3, LBU = 4'd4, LHU = 4'd5,
                           SB = 4'd6, SH = 4'd7, SW = 4'd8;
    localparam logic [1:0] R_NONE = 2'd0, R_OK = 2'd1, R_ER = 2'd2;

    typedef struct packed {
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic [31:0] ldata;
        logic        chk_ld;
        logic        exc;
        logic [3:0]  code;
    } exp_t;

    logic clk = 1'b0, rst = 1'b0;
    logic exu_req, dmem_ack;
    logic [3:0] exu_cmd;
    logic [31:0] exu_addr, exu_sdata, dmem_rdata;
    logic [1:0] dmem_resp;
    logic req_ack, ready, exc, dreq, dcmd;
    logic [31:0] ldata, daddr, wdata;
    logic [3:0] code, be;
    logic [2:0] width;
    exp_t sb[$];
    int n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    rv32im_lsu_ostd dut (
        .clk(clk), .rst(rst),
        .exu2lsu_req_i(exu_req), .exu2lsu_cmd_i(exu_cmd), .exu2lsu_addr_i(exu_addr), .exu2lsu_sdata_i(exu_sdata),
        .lsu2exu_req_ack_o(req_ack), .lsu2exu_ready_o(ready), .lsu2exu_ldata_o(ldata),
        .lsu2exu_exception_o(exc), .lsu2exu_exception_code_o(code),
        .lsu2dmem_req_o(dreq), .lsu2dmem_cmd_o(dcmd), .lsu2dmem_width_o(width),
        .lsu2dmem_addr_o(daddr), .lsu2dmem_wdata_o(wdata), .lsu2dmem_be_o(be),
        .dmem2lsu_req_ack_i(dmem_ack), .dmem2lsu_rdata_i(dmem_rdata), .dmem2lsu_resp_i(dmem_resp)
    );

    function automatic logic [31:0] model_ld(input logic [3:0] c, input logic [1:0] off, input logic [31:0] rd);
        logic [7:0] b;
        logic [15:0] h;
        b = rd[8*off +: 8];
        h = off[1] ? rd[31:16] : rd[15:0];
        case (c)
            LB:  return {{24{b[7]}}, b};
            LBU: return {24'h0, b};
            LH:  return {{16{h[15]}}, h};
            LHU: return {16'h0, h};
            LW:  return rd;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive_idle();
        exu_req = 1'b0; exu_cmd = NONE; exu_addr = '0; exu_sdata = '0;
        dmem_ack = 1'b0; dmem_rdata = '0; dmem_resp = R_NONE;
    endtask

    task automatic drive_req(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
        exu_req = 1'b1; exu_cmd = c; exu_addr = a; exu_sdata = d; dmem_ack = 1'b1;
    endtask

    task automatic expect_resp(input logic [3:0] c, input logic [31:0] a, input logic [31:0] rd, input logic [1:0] r);
        exp_t e;
        logic ld;
        ld = c inside {LB, LH, LW, LBU, LHU};
        e.resp = r; e.rdata = rd; e.ldata = model_ld(c, a[1:0], rd);
        e.chk_ld = (r == R_OK); e.exc = (r == R_ER);
        e.code = r == R_ER ? (ld ? 4'd5 : 4'd7) : 4'd0;
        sb.push_back(e);
    endtask

    task automatic drive_head(output exp_t e);
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_underflow: response requested with no expected entry queued");
            e = '0;
        end else e = sb.pop_front();
        dmem_resp = e.resp; dmem_rdata = e.rdata;
    endtask

    task automatic test_reset();
        rst = 1'b0; drive_idle();
        drive_req(LW, 32'h100, 32'h5); dmem_resp = R_OK;
        repeat (2) @(negedge clk);
        #1;
        n_tests++;
        if ({dreq, req_ack, ready, exc, code, ldata, wdata, be, width, dcmd, daddr} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: dreq=%0b ack=%0b rdy=%0b exc=%0b code=%0d daddr=%h, required all 0",
                     dreq, req_ack, ready, exc, code, daddr);
        end
        n_tests++;
        if ({dut.cnt, dut.flush_pending, dut.stray_resp_err} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: cnt=%0d flush=%0b stray=%0b, required 0", dut.cnt, dut.flush_pending, dut.stray_resp_err);
        end
        @(negedge clk); drive_idle(); rst = 1'b1;
    endtask

    task automatic test_lw();
        exp_t e;
        @(negedge clk); drive_idle(); drive_req(LW, 32'h100, 32'h0); #1;
        n_tests++;
        if ({dreq, req_ack, dcmd, width, be, daddr} !== {1'b1, 1'b1, 1'b0, 3'd2, 4'b0000, 32'h100}) begin
            n_fail++;
            $display("FAIL lw_issue: req=%0b ack=%0b cmd=%0b width=%0d be=%b addr=%h, required 1 1 0 2 0000 100",
                     dreq, req_ack, dcmd, width, be, daddr);
        end
        if (req_ack) expect_resp(LW, 32'h100, 32'hDEADBEEF, R_OK);
        @(negedge clk); drive_idle(); drive_head(e); #1;
        n_tests++;
        if ({ready, exc, code, ldata} !== {1'b1, 1'b0, 4'd0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL lw_resp: rdy=%0b exc=%0b code=%0d ldata=%h, required 1 0 0 deadbeef", ready, exc, code, ldata);
        end
        @(negedge clk); drive_idle(); #1;
        n_tests++;
        if ({ready, exc, dreq} !== 3'b000) begin
            n_fail++;
            $display("FAIL lw_idle: rdy=%0b exc=%0b dreq=%0b, required 0", ready, exc, dreq);
        end
    endtask

    task automatic test_lb_lbu();
        logic [3:0]  cs [4] = '{LB, LBU, LH, LHU};
        logic [31:0] as [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        logic [31:0] rds[4] = '{32'h80000000, 32'h80000000, 32'h80010000, 32'h80010000};
        logic [31:0] xs [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001, 32'h00008001};
        exp_t e;
        for (int p = 0; p < 4; p += 2) begin
            for (int k = 0; k < 2; k++) begin
                @(negedge clk); drive_idle(); drive_req(cs[p+k], as[p+k], 32'h0); #1;
                n_tests++;
                if ({req_ack, dcmd} !== 2'b10) begin
                    n_fail++;
                    $display("FAIL ld_issue[%0d]: ack=%0b cmd=%0b, required ack=1 cmd=0", p + k, req_ack, dcmd);
                end
                if (req_ack) expect_resp(cs[p+k], as[p+k], rds[p+k], R_OK);
            end
            for (int k = 0; k < 2; k++) begin
                @(negedge clk); drive_idle(); drive_head(e); #1;
                n_tests++;
                if ({ready, exc, ldata} !== {1'b1, 1'b0, xs[p+k]} || ldata !== e.ldata) begin
                    n_fail++;
                    $display("FAIL ld_ext[%0d]: rdy=%0b exc=%0b ldata=%h, required 1 0 %h", p + k, ready, exc, ldata, xs[p+k]);
                end
            end
        end
    endtask

    task automatic test_store();
        logic [3:0]  cs[3] = '{SH, SB, SW};
        logic [31:0] as[3] = '{32'h102, 32'h101, 32'h104};
        logic [31:0] ds[3] = '{32'h00001234, 32'h000000AB, 32'hCAFEF00D};
        logic [31:0] ws[3] = '{32'h12341234, 32'hABABABAB, 32'hCAFEF00D};
        logic [3:0]  bs[3] = '{4'b1100, 4'b0010, 4'b1111};
        logic [2:0]  wd[3] = '{3'd1, 3'd0, 3'd2};
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); drive_idle(); drive_req(cs[i], as[i], ds[i]); #1;
            n_tests++;
            if ({dreq, req_ack, dcmd, width, wdata, be} !== {1'b1, 1'b1, 1'b1, wd[i], ws[i], bs[i]}) begin
                n_fail++;
                $display("FAIL st_issue[%0d]: ack=%0b cmd=%0b width=%0d wdata=%h be=%b, required 1 1 %0d %h %b",
                         i, req_ack, dcmd, width, wdata, be, wd[i], ws[i], bs[i]);
            end
            if (req_ack) expect_resp(cs[i], as[i], 32'hFFFFFFFF, R_OK);
            @(negedge clk); drive_idle(); drive_head(e); #1;
            n_tests++;
            if ({ready, exc, code, ldata} !== {1'b1, 1'b0, 4'd0, 32'h0}) begin
                n_fail++;
                $display("FAIL st_resp[%0d]: rdy=%0b exc=%0b code=%0d ldata=%h, required 1 0 0 0", i, ready, exc, code, ldata);
            end
        end
    endtask

    task automatic test_misaligned();
        logic [3:0]  cs[4] = '{LW, LH, SW, SH};
        logic [31:0] as[4] = '{32'h101, 32'h103, 32'h102, 32'h101};
        logic [3:0]  xc[4] = '{4'd4, 4'd4, 4'd6, 4'd6};
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); drive_idle(); drive_req(cs[i], as[i], 32'h0); #1;
            n_tests++;
            if ({ready, exc, code, dreq, req_ack} !== {1'b1, 1'b1, xc[i], 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL mis[%0d]: rdy=%0b exc=%0b code=%0d dreq=%0b ack=%0b, required 1 1 %0d 0 0",
                         i, ready, exc, code, dreq, req_ack, xc[i]);
            end
        end
        @(negedge clk); drive_idle(); drive_req(NONE, 32'h100, 32'h0); #1;
        n_tests++;
        if ({dreq, req_ack, ready, exc} !== 4'b0000) begin
            n_fail++;
            $display("FAIL invalid_cmd: dreq=%0b ack=%0b rdy=%0b exc=%0b, required 0", dreq, req_ack, ready, exc);
        end
        @(negedge clk); drive_idle(); drive_req(LW, 32'h110, 32'h0); #1;
        if (req_ack) expect_resp(LW, 32'h110, 32'h11223344, R_OK);
        @(negedge clk); drive_idle(); drive_req(SW, 32'h112, 32'h0); drive_head(e); #1;
        n_tests++;
        if ({ready, exc, code, ldata, dreq} !== {1'b1, 1'b0, 4'd0, 32'h11223344, 1'b0}) begin
            n_fail++;
            $display("FAIL mis_vs_resp: rdy=%0b exc=%0b code=%0d ldata=%h dreq=%0b, required 1 0 0 11223344 0",
                     ready, exc, code, ldata, dreq);
        end
        @(negedge clk); dmem_resp = R_NONE; #1;
        n_tests++;
        if ({ready, exc, code} !== {1'b1, 1'b1, 4'd6}) begin
            n_fail++;
            $display("FAIL mis_after_resp: rdy=%0b exc=%0b code=%0d, required 1 1 6", ready, exc, code);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rds[3] = '{32'hA0A0A0A1, 32'hB0B0B0B2, 32'hC0C0C0C3};
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive_idle(); drive_req(LW, 32'h200 + 4 * i, 32'h0); #1;
            n_tests++;
            if (req_ack !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_issue[%0d]: ack=%0b, required 1", i, req_ack);
            end
            if (req_ack) expect_resp(LW, 32'h200 + 4 * i, rds[i], R_OK);
        end
        @(negedge clk); drive_idle(); drive_req(LW, 32'h208, 32'h0); #1;
        n_tests++;
        if ({dreq, req_ack} !== 2'b00) begin
            n_fail++;
            $display("FAIL b2b_full: dreq=%0b ack=%0b, required 0 0", dreq, req_ack);
        end
        @(negedge clk); drive_head(e); #1;
        n_tests++;
        if ({dreq, ready, ldata} !== {1'b0, 1'b1, e.ldata}) begin
            n_fail++;
            $display("FAIL b2b_first_resp: dreq=%0b rdy=%0b ldata=%h, required 0 1 %h", dreq, ready, ldata, e.ldata);
        end
        @(negedge clk); dmem_resp = R_NONE; #1;
        n_tests++;
        if ({dreq, req_ack} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_third_accept: dreq=%0b ack=%0b, required 1 1", dreq, req_ack);
        end
        if (req_ack) expect_resp(LW, 32'h208, rds[2], R_OK);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); drive_idle(); drive_head(e); #1;
            n_tests++;
            if ({ready, exc, ldata} !== {1'b1, 1'b0, e.ldata}) begin
                n_fail++;
                $display("FAIL b2b_order[%0d]: rdy=%0b exc=%0b ldata=%h, required 1 0 %h", i, ready, exc, ldata, e.ldata);
            end
        end
    endtask

    task automatic test_error_flush();
        exp_t e;
        logic got;
        int waited;
        @(negedge clk); drive_idle(); drive_req(SW, 32'h300, 32'h99); #1;
        if (req_ack) expect_resp(SW, 32'h300, 32'h0, R_ER);
        @(negedge clk); drive_idle(); drive_req(LW, 32'h304, 32'h0); #1;
        if (req_ack) expect_resp(LW, 32'h304, 32'h55667788, R_OK);
        @(negedge clk); drive_idle(); drive_head(e); #1;
        n_tests++;
        if ({ready, exc, code} !== {1'b1, 1'b1, 4'd7}) begin
            n_fail++;
            $display("FAIL st_err: rdy=%0b exc=%0b code=%0d, required 1 1 7", ready, exc, code);
        end
        @(negedge clk); drive_idle(); drive_req(LW, 32'h308, 32'h0); #1;
        n_tests++;
        if (dreq !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_block: dreq=%0b, required 0", dreq);
        end
        @(negedge clk); drive_head(e); #1;
        n_tests++;
        if ({ready, exc, ldata, dreq} !== {1'b1, 1'b0, 32'h55667788, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_drain: rdy=%0b exc=%0b ldata=%h dreq=%0b, required 1 0 55667788 0", ready, exc, ldata, dreq);
        end
        got = 1'b0; waited = 0;
        for (int w = 1; w <= 6 && !got; w++) begin
            @(negedge clk); dmem_resp = R_NONE; #1;
            if (req_ack) begin got = 1'b1; waited = w; end
        end
        n_tests++;
        if (!got || waited != 2) begin
            n_fail++;
            $display("FAIL flush_release: accepted=%0b after %0d cycles, required accept after 2", got, waited);
        end
        if (got) expect_resp(LW, 32'h308, 32'h0, R_ER);
        @(negedge clk); drive_idle(); drive_head(e); #1;
        n_tests++;
        if ({ready, exc, code} !== {1'b1, 1'b1, 4'd5}) begin
            n_fail++;
            $display("FAIL ld_err: rdy=%0b exc=%0b code=%0d, required 1 1 5", ready, exc, code);
        end
        got = 1'b0;
        @(negedge clk); drive_idle(); drive_req(LW, 32'h30C, 32'h0);
        for (int w = 0; w < 4 && !got; w++) begin
            #1;
            if (req_ack) got = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (got !== 1'b1 || dut.cnt !== 2'd1) begin
            n_fail++;
            $display("FAIL rst_setup: accepted=%0b cnt=%0d, required 1 1", got, dut.cnt);
        end
        drive_idle(); rst = 1'b0; #1;
        n_tests++;
        if ({dut.cnt, dut.flush_pending} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_mid: cnt=%0d flush=%0b, required 0 0", dut.cnt, dut.flush_pending);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); dmem_resp = R_OK; dmem_rdata = 32'h12345678; #1;
        n_tests++;
        if ({ready, exc, ldata} !== {1'b0, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL stray_resp: rdy=%0b exc=%0b ldata=%h, required 0 0 0", ready, exc, ldata);
        end
        @(negedge clk); drive_idle(); #1;
        n_tests++;
        if ({dut.stray_resp_err, dut.cnt} !== 3'b100) begin
            n_fail++;
            $display("FAIL stray_sticky: err=%0b cnt=%0d, required 1 0", dut.stray_resp_err, dut.cnt);
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d entries, required 0", sb.size());
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_lw();
        test_lb_lbu();
        test_store();
        test_misaligned();
        test_back_to_back();
        test_error_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rv32im_lsu_ostd.md
RV32IM_LSU_OSTD -- requirements
Module: rv32im_lsu_ostd

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (32 only; other values are a synthesis error).
REQ-003 SHALL have parameter OST_DEPTH, default 2, max outstanding DMEM requests (power of 2, >=1).
REQ-004 SHALL have ports `clk` (in, 1, sole clock) and `rst` (in, 1); `rst` is asynchronous and active-low.
REQ-005 SHALL have `exu2lsu_req_i` (in, 1), the EXU request.
REQ-006 SHALL have `exu2lsu_cmd_i` (in, LSU_OPCODE_SIZE), LSU_CMD_* encoding from DEFINITIONS.v.
REQ-007 SHALL have `exu2lsu_addr_i` (in, ADDR_W) and `exu2lsu_sdata_i` (in, DATA_W), the byte address and the store data (LSB-aligned).
REQ-008 SHALL have `lsu2exu_req_ack_o` (out, 1), the request acceptance.
REQ-009 SHALL have `lsu2exu_ready_o` (out, 1), response completed.
REQ-010 SHALL have `lsu2exu_ldata_o` (out, DATA_W), load result.
REQ-011 SHALL have `lsu2exu_exception_o` (out, 1) and `lsu2exu_exception_code_o` (out, 4), the exception flag and its code.
REQ-012 SHALL have `lsu2dmem_req_o` (out, 1), `lsu2dmem_cmd_o` (out, 1) and `lsu2dmem_width_o` (out, 3), using MEM_CMD_* and MEM_WIDTH_* from memifdef.v.
REQ-013 SHALL have `lsu2dmem_addr_o` (out, ADDR_W), `lsu2dmem_wdata_o` (out, DATA_W) and `lsu2dmem_be_o` (out, DATA_W/8), the address, lane-aligned write data and byte enables.
REQ-014 SHALL have `dmem2lsu_req_ack_i` (in, 1), `dmem2lsu_rdata_i` (in, DATA_W) and `dmem2lsu_resp_i` (in, 2), using MEM_RESP_* from memifdef.v.

Function
REQ-015 SHALL classify cmd: LB/LH/LW/LBU/LHU are loads, SB/SH/SW are stores, NONE/other is invalid (no DMEM request, no ack).
REQ-016 SHALL flag misalignment combinationally: word with addr[1:0]!=0, or half with addr[0]!=0.
REQ-017 On a misaligned request SHALL assert `lsu2exu_exception_o`=1 in the same cycle, with code 4 (load) or 6 (store); `lsu2exu_ready_o`=1, no DMEM request, no queue push.
REQ-018 SHALL drive `lsu2dmem_req_o` = req & valid cmd & ~misaligned & ~queue_full & ~flush_pending.
REQ-019 Accept (`lsu2exu_req_ack_o`=1) SHALL occur only when `lsu2dmem_req_o` & `dmem2lsu_req_ack_i`; accept pushes {cmd, addr[1:0]} into an in-order tracking queue of OST_DEPTH entries.
REQ-020 SHALL drive `lsu2dmem_addr_o` = `exu2lsu_addr_i`, and `lsu2dmem_cmd_o` = READ for loads, WRITE otherwise.
REQ-021 Store lanes: SB SHALL replicate the byte ×4 with be=1<<addr[1:0]; SH SHALL replicate the half ×2 with be=4'b0011<<addr[1:0]; SW SHALL pass data with be=4'b1111; loads SHALL drive be=0.
REQ-022 A response (`dmem2lsu_resp_i` = RDY_OK or RDY_ER) with a non-empty queue SHALL pop the head and assert `lsu2exu_ready_o` for 1 cycle.
REQ-023 A response with an empty queue SHALL be ignored: no pop, no ready, sticky internal error bit set (visible to the bench via hierarchy).
REQ-024 Load data SHALL be taken from rdata >> (8*head.addr[1:0]), then sign-extended (LB/LH) or zero-extended (LBU/LHU); LW is passed as-is; stores SHALL drive ldata=0.
REQ-025 RDY_ER SHALL give exception=1, code 5 (load) or 7 (store); on RDY_OK exception=0.
REQ-026 When a misalignment coincides with a response, the response SHALL be reported and the misaligned request held off (no ready for it) until a non-response cycle.
REQ-027 After an RDY_ER, flush_pending SHALL be set: new requests are blocked until the queue drains, then flush_pending clears the next cycle.
REQ-028 Push and pop in the same cycle SHALL leave the count unchanged; push when full is impossible per REQ-018.
REQ-029 The count SHALL be held in a clog2(OST_DEPTH)+1-bit counter, with pointers wrapping modulo OST_DEPTH.
REQ-030 Outputs not covered by REQ-016..REQ-029 SHALL be 0 when idle.

Reset
REQ-031 While `rst`=0 SHALL clear the queue, count, pointers, flush_pending and the sticky error bit; all outputs 0 except exception_code=0.
REQ-032 Assertion mid-transaction SHALL discard outstanding entries; responses arriving after release with an empty queue follow REQ-023.

Verification
REQ-033 LW addr 0x100, ack=1, next-cycle RDY_OK rdata 0xDEADBEEF -> ack then ready=1, ldata=0xDEADBEEF, exception=0.
REQ-034 LB addr 0x103, rdata 0x80000000 -> ldata=0xFFFFFF80; LBU same -> 0x00000080.
REQ-035 SH addr 0x102, sdata 0x1234 -> wdata=0x12341234, be=4'b1100, cmd=WRITE.
REQ-036 LW addr 0x101 -> same-cycle exception=1, code=4, ready=1, lsu2dmem_req_o=0.
REQ-037 OST_DEPTH=2, three back-to-back LW with no response -> third has req_o=0; after one RDY_OK third is accepted; responses are returned in order.
REQ-038 SW gets RDY_ER with one load outstanding -> code=7, req blocked until the load responds; then accepts; rst pulse mid-flight clears the count to 0.
